xilinx_tdp_ram_be: RTL and testbench

True dual-port block RAM with per-byte write enables, selectable read-during-write mode, optional output pipeline register and a built-in post-reset clear sequencer. Successor to the single-mode, line-wide-WE dual-port RAM: backs caches, tag stores and register-file banks that need partial writes, deterministic startup contents and a registered read path for timing closure. Infers one or more Xilinx BRAM primitives (`ram_style = "block"`).

---
 rtl/xilinx_tdp_ram_be_if.sv | 26 ++
 rtl/xilinx_tdp_ram_be.sv | 168 ++++++++++++++++
 tb/tb_xilinx_tdp_ram_be.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/xilinx_tdp_ram_be_if.sv
// Bus bundle for both ports of xilinx_tdp_ram_be: access controls, read data/valid,
// collision flag and init status.
interface xilinx_tdp_ram_be_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9,
  parameter int NB         = 4
);
  logic                  en_a, en_b;
  logic [NB-1:0]         we_a, we_b;
  logic [ADDR_WIDTH-1:0] addr_a, addr_b;
  logic [DATA_WIDTH-1:0] data_in_a, data_in_b;
  logic [DATA_WIDTH-1:0] data_out_a, data_out_b;
  logic                  valid_a, valid_b;
  logic                  collision;
  logic                  init_done;

  modport master (
    output en_a, en_b, we_a, we_b, addr_a, addr_b, data_in_a, data_in_b,
    input  data_out_a, data_out_b, valid_a, valid_b, collision, init_done
  );

  modport slave (
    input  en_a, en_b, we_a, we_b, addr_a, addr_b, data_in_a, data_in_b,
    output data_out_a, data_out_b, valid_a, valid_b, collision, init_done
  );
endinterface

// File: rtl/xilinx_tdp_ram_be.sv
// True dual-port byte-enable block RAM with selectable read-during-write mode and optional
// output register. Define XILINX_TDP_RAM_CLEAR_EN to add the post-reset zero-fill sequencer.
module xilinx_tdp_ram_be #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 512,
  parameter int BYTE_WIDTH = 8,
  parameter int RDW_MODE   = 0,
  parameter int OUT_REG    = 0
) (
  input logic               clk,
  input logic               rst_n,
  xilinx_tdp_ram_be_if.slave bus
);
  localparam int NB = DATA_WIDTH / BYTE_WIDTH;
  localparam int AW = $clog2(DEPTH);

  (* ram_style = "block" *) logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic            init_q;
  logic            acc_ok;
  logic            clearing;
  logic [AW-1:0]   clr_addr;

`ifdef XILINX_TDP_RAM_CLEAR_EN
  typedef enum logic {CLEAR, READY} state_e;
  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == CLEAR) begin
      cnt_d = cnt_q + AW'(1);
      if (cnt_q == AW'(DEPTH - 1)) state_d = READY;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      init_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      init_q  <= (state_d == READY);
    end
  end

  assign clearing = rst_n && (state_q == CLEAR);
  assign clr_addr = cnt_q;
`else
  always_ff @(posedge clk) begin
    if (!rst_n) init_q <= 1'b0;
    else        init_q <= 1'b1;
  end

  assign clearing = 1'b0;
  assign clr_addr = '0;
`endif

  // User accesses are accepted only once init_done is already visible.
  assign acc_ok = rst_n && init_q;

  logic [AW-1:0]         addr_a_e, addr_b_e;
  logic [NB-1:0]         we_a_e, we_b_e;
  logic [DATA_WIDTH-1:0] din_a_e;

  always_comb begin
    addr_a_e = bus.addr_a;
    din_a_e  = bus.data_in_a;
    we_a_e   = (acc_ok && bus.en_a) ? bus.we_a : '0;
    if (clearing) begin
      addr_a_e = clr_addr;
      din_a_e  = '0;
      we_a_e   = '1;
    end
    addr_b_e = bus.addr_b;
    we_b_e   = (acc_ok && bus.en_b) ? bus.we_b : '0;
  end

  // Port B lanes are written last so it wins on overlapping lanes at the same address.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NB; i++) begin
      if (we_a_e[i]) mem_q[addr_a_e][i*BYTE_WIDTH +: BYTE_WIDTH] <= din_a_e[i*BYTE_WIDTH +: BYTE_WIDTH];
      if (we_b_e[i]) mem_q[addr_b_e][i*BYTE_WIDTH +: BYTE_WIDTH] <= bus.data_in_b[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
  end

  function automatic logic [DATA_WIDTH:0] rd_port(
    input logic                  en,
    input logic [NB-1:0]         we,
    input logic [DATA_WIDTH-1:0] old,
    input logic [DATA_WIDTH-1:0] din
  );
    logic [DATA_WIDTH-1:0] merged;
    logic [DATA_WIDTH:0]   res;
    merged = old;
    for (int unsigned i = 0; i < NB; i++)
      if (we[i]) merged[i*BYTE_WIDTH +: BYTE_WIDTH] = din[i*BYTE_WIDTH +: BYTE_WIDTH];
    case (RDW_MODE)
      0:       res = {en, merged};
      1:       res = {en, old};
      default: res = {en && (we == '0), old};
    endcase
    return res;
  endfunction

  logic [DATA_WIDTH:0]   rd_a_d, rd_b_d;
  logic [DATA_WIDTH-1:0] d1_a_q, d1_b_q;
  logic                  v1_a_q, v1_b_q, coll_q;
  logic                  coll_d;

  always_comb begin
    rd_a_d = rd_port(acc_ok && bus.en_a, bus.we_a, mem_q[bus.addr_a], bus.data_in_a);
    rd_b_d = rd_port(acc_ok && bus.en_b, bus.we_b, mem_q[bus.addr_b], bus.data_in_b);
    coll_d = acc_ok && bus.en_a && bus.en_b && (bus.addr_a == bus.addr_b)
             && ((|bus.we_a) || (|bus.we_b));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      d1_a_q <= '0;
      d1_b_q <= '0;
      v1_a_q <= 1'b0;
      v1_b_q <= 1'b0;
      coll_q <= 1'b0;
    end else begin
      v1_a_q <= rd_a_d[DATA_WIDTH];
      v1_b_q <= rd_b_d[DATA_WIDTH];
      if (rd_a_d[DATA_WIDTH]) d1_a_q <= rd_a_d[DATA_WIDTH-1:0];
      if (rd_b_d[DATA_WIDTH]) d1_b_q <= rd_b_d[DATA_WIDTH-1:0];
      coll_q <= coll_d;
    end
  end

  if (OUT_REG != 0) begin : g_oreg
    logic [DATA_WIDTH-1:0] d2_a_q, d2_b_q;
    logic                  v2_a_q, v2_b_q;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        d2_a_q <= '0;
        d2_b_q <= '0;
        v2_a_q <= 1'b0;
        v2_b_q <= 1'b0;
      end else begin
        d2_a_q <= d1_a_q;
        d2_b_q <= d1_b_q;
        v2_a_q <= v1_a_q;
        v2_b_q <= v1_b_q;
      end
    end

    assign bus.data_out_a = d2_a_q;
    assign bus.data_out_b = d2_b_q;
    assign bus.valid_a    = v2_a_q;
    assign bus.valid_b    = v2_b_q;
  end else begin : g_noreg
    assign bus.data_out_a = d1_a_q;
    assign bus.data_out_b = d1_b_q;
    assign bus.valid_a    = v1_a_q;
    assign bus.valid_b    = v1_b_q;
  end

  assign bus.collision = coll_q;
  assign bus.init_done = init_q;
endmodule

// File: tb/tb_xilinx_tdp_ram_be.sv
// Self-checking bench: six RAM configurations (RDW_MODE 0..2 x OUT_REG 0..1) share one
// stimulus stream and are compared each cycle against a word-level behavioural model.
`timescale 1ns/1ps
module tb_xilinx_tdp_ram_be;
  localparam int DW = 32, DEPTH = 16, BW = 8, NB = 4, AW = 4, NCFG = 6;
`ifdef XILINX_TDP_RAM_CLEAR_EN
  localparam int INIT_EDGES = DEPTH;
`else
  localparam int INIT_EDGES = 1;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en_a, en_b;
  logic [NB-1:0] we_a, we_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [DW-1:0] din_a, din_b;

  logic [DW-1:0] dout_a [NCFG];
  logic [DW-1:0] dout_b [NCFG];
  logic          val_a  [NCFG];
  logic          val_b  [NCFG];
  logic          coll   [NCFG];
  logic          initd  [NCFG];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    xilinx_tdp_ram_be_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NB(NB)) ifc ();
    assign ifc.en_a      = en_a;
    assign ifc.en_b      = en_b;
    assign ifc.we_a      = we_a;
    assign ifc.we_b      = we_b;
    assign ifc.addr_a    = addr_a;
    assign ifc.addr_b    = addr_b;
    assign ifc.data_in_a = din_a;
    assign ifc.data_in_b = din_b;
    assign dout_a[g] = ifc.data_out_a;
    assign dout_b[g] = ifc.data_out_b;
    assign val_a[g]  = ifc.valid_a;
    assign val_b[g]  = ifc.valid_b;
    assign coll[g]   = ifc.collision;
    assign initd[g]  = ifc.init_done;

    xilinx_tdp_ram_be #(
      .DATA_WIDTH(DW), .DEPTH(DEPTH), .BYTE_WIDTH(BW),
      .RDW_MODE(g % 3), .OUT_REG(g / 3)
    ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (ifc.slave)
    );
  end

  // Behavioural model: word memory plus, per config/port, the most recent read result
  // (what the first output stage shows) and the one before it (second stage).
  logic [DW-1:0] mem_m [DEPTH];
  bit            mem_k [DEPTH];
  logic [DW-1:0] cur_d [NCFG][2];
  logic [DW-1:0] prv_d [NCFG][2];
  bit            cur_k [NCFG][2];
  bit            prv_k [NCFG][2];
  bit            cur_v [NCFG][2];
  bit            prv_v [NCFG][2];
  bit            exp_coll, exp_init, started;
  int            hi_edges;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input int c, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cfg%0d @%0t: got %h expected %h", nm, c, $time, act, exp);
    end
  endtask

  task automatic model_edge();
    bit            en [2];
    logic [NB-1:0] we [2];
    logic [AW-1:0] ad [2];
    logic [DW-1:0] din [2];
    logic [DW-1:0] old [2];
    logic [DW-1:0] res;
    bit            xc [2];
    bit            k, ready;
    en[0] = en_a;  en[1] = en_b;
    we[0] = we_a;  we[1] = we_b;
    ad[0] = addr_a; ad[1] = addr_b;
    din[0] = din_a; din[1] = din_b;
    for (int c = 0; c < NCFG; c++)
      for (int p = 0; p < 2; p++) begin
        prv_d[c][p] = cur_d[c][p];
        prv_k[c][p] = cur_k[c][p];
        prv_v[c][p] = cur_v[c][p];
      end
    if (!rst_n) begin
      for (int c = 0; c < NCFG; c++)
        for (int p = 0; p < 2; p++) begin
          cur_d[c][p] = '0; cur_k[c][p] = 1; cur_v[c][p] = 0;
          prv_d[c][p] = '0; prv_k[c][p] = 1; prv_v[c][p] = 0;
        end
      exp_coll = 0;
      exp_init = 0;
      hi_edges = 0;
      started  = 1;
      return;
    end
    ready = exp_init;
    hi_edges++;
    exp_coll = 0;
    for (int c = 0; c < NCFG; c++)
      for (int p = 0; p < 2; p++) cur_v[c][p] = 0;
    if (ready) begin
      exp_coll = en[0] && en[1] && (ad[0] == ad[1]) && ((we[0] != 0) || (we[1] != 0));
      for (int p = 0; p < 2; p++) begin
        old[p] = mem_m[ad[p]];
        xc[p]  = en[1-p] && (ad[0] == ad[1]) && (we[1-p] != 0);
      end
      for (int c = 0; c < NCFG; c++)
        for (int p = 0; p < 2; p++) begin
          if (!en[p]) continue;
          if ((c % 3) == 2 && we[p] != 0) continue;
          res = old[p];
          k   = mem_k[ad[p]];
          if ((c % 3) == 0) begin
            for (int i = 0; i < NB; i++)
              if (we[p][i]) res[i*BW +: BW] = din[p][i*BW +: BW];
            k = k || (we[p] == '1);
          end
          if (xc[p]) k = 0;
          cur_v[c][p] = 1;
          cur_d[c][p] = res;
          cur_k[c][p] = k;
        end
      for (int p = 0; p < 2; p++)
        if (en[p]) begin
          for (int i = 0; i < NB; i++)
            if (we[p][i]) mem_m[ad[p]][i*BW +: BW] = din[p][i*BW +: BW];
          if (we[p] == '1) mem_k[ad[p]] = 1;
        end
    end
`ifdef XILINX_TDP_RAM_CLEAR_EN
    if (hi_edges <= DEPTH) begin
      mem_m[hi_edges-1] = '0;
      mem_k[hi_edges-1] = 1;
    end
`endif
    exp_init = (hi_edges >= INIT_EDGES);
  endtask

  always @(negedge clk) begin
    if (started) begin
      for (int c = 0; c < NCFG; c++) begin
        bit two;
        two = (c / 3) != 0;
        chk("valid_a", c, DW'(val_a[c]), DW'(two ? prv_v[c][0] : cur_v[c][0]));
        chk("valid_b", c, DW'(val_b[c]), DW'(two ? prv_v[c][1] : cur_v[c][1]));
        if (two ? prv_k[c][0] : cur_k[c][0])
          chk("data_out_a", c, dout_a[c], two ? prv_d[c][0] : cur_d[c][0]);
        if (two ? prv_k[c][1] : cur_k[c][1])
          chk("data_out_b", c, dout_b[c], two ? prv_d[c][1] : cur_d[c][1]);
        chk("collision", c, DW'(coll[c]), DW'(exp_coll));
        chk("init_done", c, DW'(initd[c]), DW'(exp_init));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    en_a = 0; en_b = 0; we_a = '0; we_b = '0;
  endtask

  task automatic port_a(input logic [NB-1:0] we, input logic [AW-1:0] ad, input logic [DW-1:0] d);
    en_a = 1; we_a = we; addr_a = ad; din_a = d;
  endtask

  task automatic port_b(input logic [NB-1:0] we, input logic [AW-1:0] ad, input logic [DW-1:0] d);
    en_b = 1; we_b = we; addr_b = ad; din_b = d;
  endtask

  initial begin
    int n;
    started = 0; exp_init = 0; exp_coll = 0; hi_edges = 0;
    for (int a = 0; a < DEPTH; a++) begin mem_m[a] = '0; mem_k[a] = 0; end
    idle();
    addr_a = '0; addr_b = '0; din_a = '0; din_b = '0;
    rst_n = 0;
    repeat (3) step();
    chk("reset_data_out_a", 0, dout_a[0], 32'h0);
    chk("reset_valid_a", 3, DW'(val_a[3]), 32'h0);
    chk("reset_init_done", 0, DW'(initd[0]), 32'h0);

    // Release, re-enter reset after 5 cycles, then time the init sequence.
    rst_n = 1;
    repeat (5) step();
    rst_n = 0;
    repeat (2) step();
    rst_n = 1;
    n = 0;
    do begin step(); n++; end while (!initd[0] && n < 100);
    chk("init_latency", 0, DW'(n), DW'(INIT_EDGES));

`ifndef XILINX_TDP_RAM_CLEAR_EN
    for (int a = 0; a < DEPTH; a++) begin port_a('1, AW'(a), '0); step(); end
    idle(); step();
`endif
    for (int a = 0; a < DEPTH; a++) begin
      port_a('0, AW'(a), 32'hDEAD_BEEF);
      step();
      chk("clear_read", 0, dout_a[0], 32'h0);
      chk("clear_valid", 0, DW'(val_a[0]), 32'h1);
    end
    idle(); step();

    // Byte-lane write
    port_a(4'hF, 4'd3, 32'hAABB_CCDD); step();
    port_a(4'b0101, 4'd3, 32'h1122_3344); step();
    chk("wf_merge", 0, dout_a[0], 32'hAA22_CC44);
    chk("rf_merge", 1, dout_a[1], 32'hAABB_CCDD);
    port_a(4'h0, 4'd3, '0); step();
    chk("byte_write", 0, dout_a[0], 32'hAA22_CC44);

    // Read-during-write modes
    port_a(4'hF, 4'd5, 32'h1234_5678); step();
    port_a(4'h0, 4'd5, '0); step();
    port_a(4'hF, 4'd5, 32'hCAFE_F00D); step();
    chk("rdw_write_first", 0, dout_a[0], 32'hCAFE_F00D);
    chk("rdw_read_first", 1, dout_a[1], 32'h1234_5678);
    chk("rdw_no_change", 2, dout_a[2], 32'h1234_5678);
    chk("rdw_no_change_valid", 2, DW'(val_a[2]), 32'h0);
    idle(); step();

    // Collision: B wins
    port_a(4'hF, 4'd7, 32'h1111_1111);
    port_b(4'hF, 4'd7, 32'h2222_2222);
    step();
    chk("collision_pulse", 0, DW'(coll[0]), 32'h1);
    idle(); step();
    chk("collision_drop", 0, DW'(coll[0]), 32'h0);
    port_a(4'h0, 4'd7, '0); step();
    chk("collision_winner", 0, dout_a[0], 32'h2222_2222);
    idle();

    // Latency: back-to-back reads of 0,1,2
    for (int a = 0; a < 3; a++) begin port_b(4'hF, AW'(a), 32'hB0B0_0000 + a); step(); end
    idle(); step();
    port_a(4'h0, 4'd0, '0); step();
    chk("lat1_valid_n1", 0, DW'(val_a[0]), 32'h1);
    chk("lat1_data_n1", 0, dout_a[0], 32'hB0B0_0000);
    chk("lat2_valid_n1", 3, DW'(val_a[3]), 32'h0);
    port_a(4'h0, 4'd1, '0); step();
    chk("lat2_valid_n2", 3, DW'(val_a[3]), 32'h1);
    chk("lat2_data_n2", 3, dout_a[3], 32'hB0B0_0000);
    port_a(4'h0, 4'd2, '0); step();
    chk("lat2_data_n3", 3, dout_a[3], 32'hB0B0_0001);
    idle(); step();
    chk("lat1_valid_n4", 0, DW'(val_a[0]), 32'h0);
    chk("lat2_data_n4", 3, dout_a[3], 32'hB0B0_0002);
    step();
    chk("lat2_valid_n5", 3, DW'(val_a[3]), 32'h0);

    // Randomized traffic
    repeat (600) begin
      en_a   = ($urandom_range(0, 3) != 0);
      en_b   = ($urandom_range(0, 3) != 0);
      we_a   = ($urandom_range(0, 1) != 0) ? NB'($urandom) : '0;
      we_b   = ($urandom_range(0, 1) != 0) ? NB'($urandom) : '0;
      addr_a = AW'($urandom_range(0, DEPTH - 1));
      addr_b = ($urandom_range(0, 3) == 0) ? addr_a : AW'($urandom_range(0, DEPTH - 1));
      din_a  = $urandom;
      din_b  = $urandom;
      step();
    end
    idle();
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
